// File: rtl/komandara_common_pkg.sv
// Shared Komandara types used across interconnect blocks.
// Slice occupancy encodes the stored-beat count directly.
package komandara_common_pkg;

  typedef enum logic [1:0] {
    SLICE_EMPTY = 2'd0,
    SLICE_BUSY  = 2'd1,
    SLICE_FULL  = 2'd2
  } komandara_slice_state_e;

endpackage

// File: rtl/komandara_reg_slice.sv
// Two-entry elastic register slice: valid, data and ready all leave the block from flops,
// so neither the forward nor the backward path is combinational.
module komandara_reg_slice
  import komandara_common_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [1:0]            count_o
);

  komandara_slice_state_e state_q, state_d;
  logic [DATA_WIDTH-1:0]  main_q, skid_q;
  logic                   m_valid_q, s_ready_q;
  logic                   in_hs, out_hs;
  logic                   load_main_in, load_main_skid, load_skid;

  assign in_hs  = s_valid_i & s_ready_q;
  assign out_hs = m_valid_q & m_ready_i;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      SLICE_EMPTY: begin
        if (in_hs) begin
          load_main_in = 1'b1;
          state_d      = SLICE_BUSY;
        end
      end
      SLICE_BUSY: begin
        if (in_hs && out_hs) begin
          load_main_in = 1'b1;
        end else if (in_hs) begin
          load_skid = 1'b1;
          state_d   = SLICE_FULL;
        end else if (out_hs) begin
          state_d = SLICE_EMPTY;
        end
      end
      SLICE_FULL: begin
        // ready is low here, so only the drain side can move
        if (out_hs) begin
          load_main_skid = 1'b1;
          state_d        = SLICE_BUSY;
        end
      end
      default: state_d = SLICE_EMPTY;
    endcase
    if (flush_i) begin
      state_d        = SLICE_EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= SLICE_EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      m_valid_q <= 1'b0;
      s_ready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_valid_q <= (state_d != SLICE_EMPTY);
      s_ready_q <= (state_d != SLICE_FULL);
      if (load_main_in)   main_q <= s_data_i;
      if (load_main_skid) main_q <= skid_q;
      if (load_skid)      skid_q <= s_data_i;
    end
  end

  assign s_ready_o = s_ready_q;
  assign m_valid_o = m_valid_q;
  assign m_data_o  = main_q;
  assign count_o   = state_q;

`ifndef SYNTHESIS
  a_stall_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (m_valid_o && !m_ready_i && !flush_i) |=> (m_valid_o && $stable(m_data_o)));
  a_full_not_ready: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(state_q == SLICE_FULL && s_ready_o));
  a_count_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    count_o < 2'd3);
`endif

endmodule
